// File: rtl/layer1_feeder.sv
// layer1_feeder: sequences one fully-connected layer through a single
// multiply-accumulate neuron. For each output neuron j it loads the bias,
// streams N_IN activation/weight pairs, waits out the neuron's two-stage
// product/accumulate pipeline and writes the ReLU result back.
//
// Optional feature: define LAYER1_FEEDER_SKIP_ZERO_EN to suppress the neuron
// valid strobe in MAC cycles whose activation word is zero. Cycle count and
// results are unchanged; only the neuron's accumulate activity drops.
//
// value, weight, valid and res_data pass RAM and neuron data through gates
// driven by registered state, because the RAM data arrives in the very cycle
// the neuron consumes it. Every other output is a register.

module layer1_feeder #(
    parameter int unsigned N_IN  = 784,
    parameter int unsigned N_OUT = 16,
    localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int unsigned WW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int unsigned BW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        act_addr,
    input  logic signed [31:0]   act_data,
    output logic [WW-1:0]        wgt_addr,
    input  logic signed [31:0]   wgt_data,
    output logic [BW-1:0]        bias_addr,
    input  logic signed [31:0]   bias_data,
    output logic                 bias_load,
    output logic                 valid,
    output logic signed [31:0]   value,
    output logic signed [31:0]   weight,
    input  logic signed [31:0]   relu_output,
    output logic                 res_we,
    output logic [BW-1:0]        res_addr,
    output logic signed [31:0]   res_data
);

    localparam logic [AW-1:0] K_LAST = AW'(N_IN - 1);
    localparam logic [BW-1:0] J_LAST = BW'(N_OUT - 1);
    localparam logic [WW-1:0] W_STEP = WW'(N_IN);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_BIAS  = 3'd1,
        LOAD_BIAS = 3'd2,
        MAC       = 3'd3,
        DRAIN     = 3'd4,
        WRITE     = 3'd5
    } state_t;

    state_t        state;
    logic [BW-1:0] j;
    logic [AW-1:0] k;
    logic [WW-1:0] wgt_base;
    logic          mac_on;
    logic          addr_last;

    // Read addresses stop at the last element of the current neuron's row
    assign addr_last = (act_addr == K_LAST);

    // Sequencer: state, counters, addresses and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            k         <= '0;
            wgt_base  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bias_load <= 1'b0;
            mac_on    <= 1'b0;
            res_we    <= 1'b0;
            act_addr  <= '0;
            wgt_addr  <= '0;
            bias_addr <= '0;
            res_addr  <= '0;
        end else begin
            done      <= 1'b0;
            bias_load <= 1'b0;
            mac_on    <= 1'b0;
            res_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= PRE_BIAS;
                        busy      <= 1'b1;
                        j         <= '0;
                        k         <= '0;
                        wgt_base  <= '0;
                        bias_addr <= '0;
                    end
                end
                PRE_BIAS: begin
                    state     <= LOAD_BIAS;
                    bias_load <= 1'b1;
                    k         <= '0;
                    act_addr  <= '0;
                    wgt_addr  <= wgt_base;
                end
                LOAD_BIAS: begin
                    state  <= MAC;
                    mac_on <= 1'b1;
                    if (!addr_last) begin
                        act_addr <= act_addr + AW'(1);
                        wgt_addr <= wgt_addr + WW'(1);
                    end
                end
                MAC: begin
                    if (k == K_LAST) begin
                        state <= DRAIN;
                    end else begin
                        k      <= k + AW'(1);
                        mac_on <= 1'b1;
                        if (!addr_last) begin
                            act_addr <= act_addr + AW'(1);
                            wgt_addr <= wgt_addr + WW'(1);
                        end
                    end
                end
                DRAIN: begin
                    state    <= WRITE;
                    res_we   <= 1'b1;
                    res_addr <= j;
                end
                WRITE: begin
                    if (j == J_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= PRE_BIAS;
                        j         <= j + BW'(1);
                        bias_addr <= j + BW'(1);
                        wgt_base  <= wgt_base + W_STEP;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Neuron operand steering: bias in LOAD_BIAS, act/weight pairs in MAC
    always_comb begin
        value  = '0;
        weight = '0;
        valid  = 1'b0;
        if (bias_load) begin
            value = bias_data;
        end else if (mac_on) begin
            value  = act_data;
            weight = wgt_data;
`ifdef LAYER1_FEEDER_SKIP_ZERO_EN
            valid  = (act_data != '0);
`else
            valid  = 1'b1;
`endif
        end
    end

    // Result word follows the neuron output only while writing
    always_comb begin
        res_data = '0;
        if (res_we) begin
            res_data = relu_output;
        end
    end

endmodule
